sram_ctrl: RTL and testbench

//  Parametrised single-port synchronous RAM with request/ready handshake,

---
 rtl/sram_ctrl_if.sv | 28 ++
 rtl/sram_ctrl.sv | 113 +++++++++++
 tb/tb_sram_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_if.sv
// Bus bundle for sram_ctrl: request/ready handshake, registered read return and peek view.
interface sram_ctrl_if #(
   parameter int unsigned DW = 4,
   parameter int unsigned AW = 2
);
   logic          req;
   logic          rw;
   logic [AW-1:0] addr;
   logic [DW-1:0] din;
   logic          par_flip;
   logic          ready;
   logic          busy;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          parity_err;
   logic [AW-1:0] peek_addr;
   logic [DW-1:0] peek_data;

   modport master (
      output req, rw, addr, din, par_flip, peek_addr,
      input  ready, busy, dout, dout_valid, parity_err, peek_data
   );

   modport slave (
      input  req, rw, addr, din, par_flip, peek_addr,
      output ready, busy, dout, dout_valid, parity_err, peek_data
   );
endinterface

// File: rtl/sram_ctrl.sv
// DEPTH x DW single-port RAM with handshake, registered read and post-reset clear sweep.
// Optional even-parity storage and fault injection enabled by defining SRAM_PARITY_EN.
module sram_ctrl #(
   parameter int unsigned    DW       = 4,
   parameter int unsigned    AW       = 2,
   parameter logic [DW-1:0]  INIT_VAL = '0
) (
   input logic        clk,
   input logic        rst,
   sram_ctrl_if.slave bus
);
   localparam int unsigned DEPTH = 1 << AW;

   typedef enum logic {ST_INIT, ST_IDLE} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          ready_q, ready_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          dout_valid_q, dout_valid_d;
   logic          parity_err_q, parity_err_d;

   logic [DW-1:0] mem_q [DEPTH];
   logic          we;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;

`ifdef SRAM_PARITY_EN
   logic          par_q [DEPTH];
   logic          wpar;
`else
   logic          unused_par_flip;
   assign unused_par_flip = bus.par_flip;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      parity_err_d = parity_err_q;
      we           = 1'b0;
      waddr        = cnt_q;
      wdata        = INIT_VAL;
`ifdef SRAM_PARITY_EN
      wpar         = ^INIT_VAL;
`endif
      case (state_q)
         ST_INIT: begin
            we    = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(DEPTH - 1)) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (bus.req) begin
               if (bus.rw) begin
                  we    = 1'b1;
                  waddr = bus.addr;
                  wdata = bus.din;
`ifdef SRAM_PARITY_EN
                  wpar  = (^bus.din) ^ bus.par_flip;
`endif
               end else begin
                  dout_d       = mem_q[bus.addr];
                  dout_valid_d = 1'b1;
`ifdef SRAM_PARITY_EN
                  parity_err_d = par_q[bus.addr] != (^mem_q[bus.addr]);
`else
                  parity_err_d = 1'b0;
`endif
               end
            end
         end
         default: state_d = ST_INIT;
      endcase
      ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_INIT;
         cnt_q        <= '0;
         ready_q      <= 1'b0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ready_q      <= ready_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         parity_err_q <= parity_err_d;
      end
   end

   // Array has no reset; the sweep after reset provides the known contents.
   always_ff @(posedge clk) begin
      if (we && !rst) begin
         mem_q[waddr] <= wdata;
`ifdef SRAM_PARITY_EN
         par_q[waddr] <= wpar;
`endif
      end
   end

   assign bus.ready      = ready_q;
   assign bus.busy       = ~ready_q;
   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.parity_err = parity_err_q;
   assign bus.peek_data  = mem_q[bus.peek_addr];
endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: directed scenarios followed by random traffic with occasional reset.
module tb_sram_ctrl;
   localparam int unsigned DW    = 4;
   localparam int unsigned AW    = 2;
   localparam int unsigned DEPTH = 1 << AW;
   localparam logic [DW-1:0] INIT_VAL = '0;

   typedef struct {
      logic [DW-1:0] d;
      logic          p;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   sram_ctrl_if #(.DW(DW), .AW(AW)) bus ();

   sram_ctrl #(.DW(DW), .AW(AW), .INIT_VAL(INIT_VAL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model: word contents, injected-fault flags, and a countdown of remaining clear cycles.
   logic [DW-1:0] ref_mem   [DEPTH];
   logic          ref_bad   [DEPTH];
   logic          ref_known [DEPTH];
   int unsigned   clear_left = 0;
   logic          exp_ready  = 1'b0;
   logic          mon_en     = 1'b0;
   logic          clr_hold   = 1'b0;
   exp_t          rd_q [$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      exp_t e;
      if (rst) begin
         clear_left = DEPTH;
         rd_q.delete();
         clr_hold = 1'b1;
         mon_en   = 1'b1;
      end else if (clear_left != 0) begin
         ref_mem[DEPTH - clear_left]   = INIT_VAL;
         ref_bad[DEPTH - clear_left]   = 1'b0;
         ref_known[DEPTH - clear_left] = 1'b1;
         clear_left--;
      end else if (bus.req) begin
         if (bus.rw) begin
            ref_mem[bus.addr]   = bus.din;
            ref_bad[bus.addr]   = bus.par_flip;
            ref_known[bus.addr] = 1'b1;
         end else begin
            e.d = ref_mem[bus.addr];
`ifdef SRAM_PARITY_EN
            e.p = ref_bad[bus.addr];
`else
            e.p = 1'b0;
`endif
            rd_q.push_back(e);
         end
      end
      exp_ready = (clear_left == 0);
   endtask

   task automatic step(input logic r, input logic q, input logic w, input int unsigned a,
                       input int unsigned d, input logic pf, input int unsigned pk);
      rst           = r;
      bus.req       = q;
      bus.rw        = w;
      bus.addr      = AW'(a);
      bus.din       = DW'(d);
      bus.par_flip  = pf;
      bus.peek_addr = AW'(pk);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, $urandom_range(0, DEPTH - 1));
   endtask

   // Monitor: checks handshake flags every cycle, pops the scoreboard whenever a read result is presented.
   logic [DW-1:0] hold_d = '0;
   logic          hold_p = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (clr_hold) begin
            hold_d   = '0;
            hold_p   = 1'b0;
            clr_hold = 1'b0;
         end
         chk("ready", 32'(bus.ready), 32'(exp_ready));
         chk("busy", 32'(bus.busy), 32'(!exp_ready));
         if (rd_q.size() != 0) begin
            e = rd_q.pop_front();
            hold_d = e.d;
            hold_p = e.p;
            chk("dout_valid", 32'(bus.dout_valid), 32'd1);
         end else begin
            chk("dout_valid", 32'(bus.dout_valid), 32'd0);
         end
         chk("dout", 32'(bus.dout), 32'(hold_d));
         chk("parity_err", 32'(bus.parity_err), 32'(hold_p));
         if (ref_known[bus.peek_addr])
            chk("peek_data", 32'(bus.peek_data), 32'(ref_mem[bus.peek_addr]));
      end
   end

   initial begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         ref_known[i] = 1'b0;
         ref_bad[i]   = 1'b0;
         ref_mem[i]   = '0;
      end
      bus.req = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.din = '0;
      bus.par_flip = 1'b0; bus.peek_addr = '0;

      // Reset with req held high: requests during the sweep are dropped.
      step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0);
      for (int unsigned i = 0; i < DEPTH + 2; i++)
         step(1'b0, 1'b1, i[0], i, 4'hF, 1'b0, i);

      // Back-to-back writes and reads.
      step(1'b0, 1'b1, 1'b1, 1, 4'hA, 1'b0, 1);
      step(1'b0, 1'b1, 1'b1, 3, 4'h5, 1'b0, 3);
      step(1'b0, 1'b1, 1'b0, 1, 0, 1'b0, 1);
      step(1'b0, 1'b1, 1'b0, 3, 0, 1'b0, 3);
      // Write followed immediately by read of the same word.
      step(1'b0, 1'b1, 1'b1, 2, 4'hC, 1'b0, 2);
      step(1'b0, 1'b1, 1'b0, 2, 0, 1'b0, 2);
      idle(2);

      // Reset right after a read: result cleared, sweep reruns, old data gone.
      step(1'b0, 1'b1, 1'b0, 1, 0, 1'b0, 1);
      step(1'b1, 1'b1, 1'b0, 1, 0, 1'b0, 1);
      idle(DEPTH);
      step(1'b0, 1'b1, 1'b0, 1, 0, 1'b0, 1);
      idle(1);

      // Parity fault injection and repair.
      step(1'b0, 1'b1, 1'b1, 0, 4'h7, 1'b1, 0);
      step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0);
      idle(2);
      step(1'b0, 1'b1, 1'b1, 0, 4'h7, 1'b0, 0);
      step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0);
      idle(2);

      // Fill every address with a distinct pattern, then read all back.
      for (int unsigned a = 0; a < DEPTH; a++) step(1'b0, 1'b1, 1'b1, a, (a * 5 + 3), 1'b0, a);
      for (int unsigned a = 0; a < DEPTH; a++) step(1'b0, 1'b1, 1'b0, a, 0, 1'b0, a);
      idle(2);

      // Random traffic with rare resets.
      for (int unsigned i = 0; i < 800; i++)
         step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, DEPTH - 1), $urandom, $urandom_range(0, 3) == 0,
              $urandom_range(0, DEPTH - 1));
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
